// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Line geometry is fixed: 8 x 16-bit words per 16-byte line.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int BURST_BEATS = 8;
  localparam int WORD_BYTES  = 2;
  localparam int LINE_BYTES  = 16;

  // Critical-word-first beat index: wraps inside the line by 3-bit overflow.
  function automatic logic [2:0] cwf_word(input logic [2:0] start, input logic [2:0] k);
    return start + k;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word-organised 16-bit storage: synchronous write port, asynchronous read port.
module mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [15:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [15:0]      rdata
);

  logic [15:0] mem_r [DEPTH_WORDS];

  // Array write on the clock edge; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle data-memory responder: valid/ready requests, fixed-latency
// valid-only responses, single-word reads/writes and 8-beat wrapping line bursts.
module mem_responder
  import mem_pkg::*;
#(
  parameter int LATENCY     = 4,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic              req_burst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  output logic [15:0]       rsp_data,
  output logic [ADDR_W-1:0] rsp_addr
);

  localparam int IDX_W    = $clog2(DEPTH_WORDS);
  localparam int LINE_LSB = $clog2(LINE_BYTES);
  localparam int WORD_LSB = $clog2(WORD_BYTES);
  localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       LAST_BEAT = 3'(BURST_BEATS - 1);

  state_t            state_r;
  logic [CNT_W-1:0]  wait_cnt_r;
  logic [2:0]        beat_cnt_r;
  logic              burst_r;
  logic              wr_r;
  logic [ADDR_W-1:0] addr_r;
  logic [15:0]       wdata_r;
  logic              rsp_valid_r;
  logic [15:0]       rsp_data_r;
  logic [ADDR_W-1:0] rsp_addr_r;

  logic              accept_s;
  logic [ADDR_W-1:0] src_addr_s;
  logic              src_wr_s;
  logic [15:0]       src_wdata_s;
  logic [2:0]        beat_k_s;
  logic [ADDR_W-1:0] beat_addr_s;
  logic [15:0]       beat_data_s;
  logic [15:0]       rdata_s;

  assign req_ready = (state_r == IDLE) && !rst;
  assign accept_s  = req_valid && req_ready;

  // Beat source: live request fields when issuing straight from IDLE, latched ones otherwise.
  always_comb begin
    src_addr_s  = addr_r;
    src_wr_s    = wr_r;
    src_wdata_s = wdata_r;
    beat_k_s    = 3'd0;
    case (state_r)
      IDLE: begin
        src_addr_s  = req_addr;
        src_wr_s    = req_wr;
        src_wdata_s = req_wdata;
      end
      WAIT: beat_k_s = 3'd0;
      RESP: beat_k_s = beat_cnt_r + 3'd1;
      default: beat_k_s = 3'd0;
    endcase
    beat_addr_s = {src_addr_s[ADDR_W-1:LINE_LSB],
                   cwf_word(src_addr_s[LINE_LSB-1:WORD_LSB], beat_k_s),
                   1'b0};
    if (src_wr_s) begin
      beat_data_s = src_wdata_s;
    end else begin
      beat_data_s = rdata_s;
    end
  end

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (accept_s && req_wr),
    .waddr(req_addr[IDX_W:1]),
    .wdata(req_wdata),
    .raddr(beat_addr_s[IDX_W:1]),
    .rdata(rdata_s)
  );

  // Control FSM with request latch, wait/beat counters and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      wait_cnt_r  <= '0;
      beat_cnt_r  <= 3'd0;
      burst_r     <= 1'b0;
      wr_r        <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= 16'h0000;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 16'h0000;
      rsp_addr_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          rsp_valid_r <= 1'b0;
          rsp_data_r  <= 16'h0000;
          rsp_addr_r  <= '0;
          if (accept_s) begin
            addr_r     <= req_addr;
            wr_r       <= req_wr;
            burst_r    <= req_burst && !req_wr;
            wdata_r    <= req_wdata;
            beat_cnt_r <= 3'd0;
            if (LATENCY == 1) begin
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
              rsp_data_r  <= beat_data_s;
              rsp_addr_r  <= beat_addr_s;
            end else begin
              state_r    <= WAIT;
              wait_cnt_r <= WAIT_INIT;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          wait_cnt_r <= wait_cnt_r - CNT_ONE;
          if (wait_cnt_r == CNT_ONE) begin
            state_r     <= RESP;
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= beat_data_s;
            rsp_addr_r  <= beat_addr_s;
          end else begin
            state_r <= WAIT;
          end
        end
        RESP: begin
          // Each RESP cycle is presenting beat beat_cnt_r; issue the next one or retire.
          if (burst_r && (beat_cnt_r != LAST_BEAT)) begin
            beat_cnt_r  <= beat_cnt_r + 3'd1;
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= beat_data_s;
            rsp_addr_r  <= beat_addr_s;
          end else begin
            state_r     <= IDLE;
            beat_cnt_r  <= 3'd0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 16'h0000;
            rsp_addr_r  <= '0;
          end
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
          rsp_data_r  <= 16'h0000;
          rsp_addr_r  <= '0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_addr  = rsp_addr_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: LATENCY=4 main instance
// plus a LATENCY=1 instance for the minimum-latency case.
module tb_mem_responder;

  logic        clk;
  logic        rst;

  logic        a_valid, a_ready, a_wr, a_burst;
  logic [15:0] a_addr, a_wdata;
  logic        a_rvalid;
  logic [15:0] a_rdata, a_raddr;

  logic        b_valid, b_ready, b_wr, b_burst;
  logic [15:0] b_addr, b_wdata;
  logic        b_rvalid;
  logic [15:0] b_rdata, b_raddr;

  int checks;
  int errors;

  int          cap_first, cap_last, cap_n;
  logic [15:0] cap_data [16];
  logic [15:0] cap_addr [16];

  mem_responder #(.LATENCY(4), .ADDR_W(16), .DEPTH_WORDS(1024)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid(a_valid), .req_ready(a_ready), .req_wr(a_wr), .req_burst(a_burst),
    .req_addr(a_addr), .req_wdata(a_wdata),
    .rsp_valid(a_rvalid), .rsp_data(a_rdata), .rsp_addr(a_raddr)
  );

  mem_responder #(.LATENCY(1), .ADDR_W(16), .DEPTH_WORDS(1024)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_ready(b_ready), .req_wr(b_wr), .req_burst(b_burst),
    .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rvalid), .rsp_data(b_rdata), .rsp_addr(b_raddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record response beats over the 20 cycles following an accept edge.
  task automatic capture(input bit sel);
    logic v;
    cap_first = -1;
    cap_last  = -1;
    cap_n     = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      v = sel ? b_rvalid : a_rvalid;
      if (v === 1'b1) begin
        if (cap_first < 0) cap_first = n;
        cap_last = n;
        if (cap_n < 16) begin
          cap_data[cap_n] = sel ? b_rdata : a_rdata;
          cap_addr[cap_n] = sel ? b_raddr : a_raddr;
        end
        cap_n++;
      end
    end
  endtask

  // Present one request, hold it until accepted, then capture its response.
  task automatic run_req(input bit sel, input logic wr, input logic burst,
                         input logic [15:0] addr, input logic [15:0] wdata);
    bit got;
    @(posedge clk); #1;
    if (sel) begin
      b_valid = 1'b1; b_wr = wr; b_burst = burst; b_addr = addr; b_wdata = wdata;
    end else begin
      a_valid = 1'b1; a_wr = wr; a_burst = burst; a_addr = addr; a_wdata = wdata;
    end
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if ((sel ? b_ready : a_ready) === 1'b1) got = 1'b1;
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL accept_timeout addr=%h: req_ready never 1", addr);
    end
    capture(sel);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b/%b want 0/0", a_ready, b_ready);
    end
    checks++;
    if (a_rvalid !== 1'b0 || a_rdata !== 16'h0000 || a_raddr !== 16'h0000) begin
      errors++; $display("FAIL reset_outputs got v=%b d=%h a=%h want 0/0000/0000", a_rvalid, a_rdata, a_raddr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got %b/%b want 1/1", a_ready, b_ready);
    end
  endtask

  task automatic test_write_read();
    run_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h1234);
    checks++;
    if (cap_first != 4 || cap_n != 1 || cap_data[0] !== 16'h1234 || cap_addr[0] !== 16'h0010) begin
      errors++; $display("FAIL write_ack got first=%0d n=%0d d=%h a=%h want 4/1/1234/0010", cap_first, cap_n, cap_data[0], cap_addr[0]);
    end
    run_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
    checks++;
    if (cap_first != 4 || cap_n != 1 || cap_data[0] !== 16'h1234 || cap_addr[0] !== 16'h0010) begin
      errors++; $display("FAIL read_single got first=%0d n=%0d d=%h a=%h want 4/1/1234/0010", cap_first, cap_n, cap_data[0], cap_addr[0]);
    end
  endtask

  task automatic test_burst();
    logic [15:0] exp_a [8] = '{16'h0026, 16'h0028, 16'h002A, 16'h002C, 16'h002E, 16'h0020, 16'h0022, 16'h0024};
    logic [15:0] exp_d [8] = '{16'hA003, 16'hA004, 16'hA005, 16'hA006, 16'hA007, 16'hA000, 16'hA001, 16'hA002};
    for (int i = 0; i < 8; i++) begin
      run_req(1'b0, 1'b1, 1'b0, 16'h0020 + 16'(2 * i), 16'hA000 + 16'(i));
    end
    run_req(1'b0, 1'b0, 1'b1, 16'h0026, 16'h0000);
    checks++;
    if (cap_first != 4 || cap_n != 8 || (cap_last - cap_first + 1) != 8) begin
      errors++; $display("FAIL burst_shape got first=%0d last=%0d n=%0d want 4/11/8", cap_first, cap_last, cap_n);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (cap_addr[k] !== exp_a[k] || cap_data[k] !== exp_d[k]) begin
        errors++; $display("FAIL burst_beat%0d got a=%h d=%h want a=%h d=%h", k, cap_addr[k], cap_data[k], exp_a[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ready_seen;
    @(posedge clk); #1;
    a_valid = 1'b1; a_wr = 1'b0; a_burst = 1'b0; a_addr = 16'h0010; a_wdata = 16'h0000;
    @(negedge clk);
    @(posedge clk); #1;
    a_addr = 16'h0026;
    ready_seen = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (a_ready !== 1'b0) ready_seen = 1'b1;
      if (n < 4) begin
        checks++;
        if (a_rvalid !== 1'b0) begin
          errors++; $display("FAIL bp_early_beat cycle=%0d got %b want 0", n, a_rvalid);
        end
      end
    end
    checks++;
    if (ready_seen) begin
      errors++; $display("FAIL bp_ready_low got 1 during WAIT/RESP want 0");
    end
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 16'h1234 || a_raddr !== 16'h0010) begin
      errors++; $display("FAIL bp_first_rsp got v=%b d=%h a=%h want 1/1234/0010", a_rvalid, a_rdata, a_raddr);
    end
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || a_rvalid !== 1'b0) begin
      errors++; $display("FAIL bp_ready_after got ready=%b v=%b want 1/0", a_ready, a_rvalid);
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    capture(1'b0);
    checks++;
    if (cap_first != 4 || cap_n != 1 || cap_data[0] !== 16'hA003 || cap_addr[0] !== 16'h0026) begin
      errors++; $display("FAIL bp_second_rsp got first=%0d n=%0d d=%h a=%h want 4/1/A003/0026", cap_first, cap_n, cap_data[0], cap_addr[0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    int beats;
    bit got;
    @(posedge clk); #1;
    a_valid = 1'b1; a_wr = 1'b0; a_burst = 1'b1; a_addr = 16'h0026; a_wdata = 16'h0000;
    @(negedge clk);
    @(posedge clk); #1;
    a_valid = 1'b0;
    beats = 0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (a_rvalid === 1'b1) beats++;
      if (beats == 4) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL rst_burst_timeout got %0d beats want 4", beats);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b0 || a_rdata !== 16'h0000 || a_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_burst got v=%b d=%h ready=%b want 0/0000/0", a_rvalid, a_rdata, a_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || a_rvalid !== 1'b0) begin
      errors++; $display("FAIL rst_release got ready=%b v=%b want 1/0", a_ready, a_rvalid);
    end
    run_req(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000);
    checks++;
    if (cap_first != 4 || cap_n != 1 || cap_data[0] !== 16'hA000) begin
      errors++; $display("FAIL rst_readback got first=%0d n=%0d d=%h want 4/1/A000", cap_first, cap_n, cap_data[0]);
    end
  endtask

  task automatic test_alias();
    run_req(1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000);
    checks++;
    if (cap_n != 1 || cap_data[0] !== 16'h1234 || cap_addr[0] !== 16'h0010) begin
      errors++; $display("FAIL odd_addr got n=%0d d=%h a=%h want 1/1234/0010", cap_n, cap_data[0], cap_addr[0]);
    end
    run_req(1'b0, 1'b0, 1'b0, 16'h0810, 16'h0000);
    checks++;
    if (cap_n != 1 || cap_data[0] !== 16'h1234) begin
      errors++; $display("FAIL alias_wrap got n=%0d d=%h want 1/1234", cap_n, cap_data[0]);
    end
  endtask

  task automatic test_burst_write();
    run_req(1'b0, 1'b1, 1'b1, 16'h0030, 16'h5555);
    checks++;
    if (cap_first != 4 || cap_n != 1 || cap_data[0] !== 16'h5555 || cap_addr[0] !== 16'h0030) begin
      errors++; $display("FAIL burst_write_ack got first=%0d n=%0d d=%h a=%h want 4/1/5555/0030", cap_first, cap_n, cap_data[0], cap_addr[0]);
    end
    run_req(1'b0, 1'b0, 1'b0, 16'h0030, 16'h0000);
    checks++;
    if (cap_data[0] !== 16'h5555) begin
      errors++; $display("FAIL burst_write_data got %h want 5555", cap_data[0]);
    end
  endtask

  task automatic test_latency1();
    run_req(1'b1, 1'b1, 1'b1, 16'h0041, 16'hBEEF);
    checks++;
    if (cap_first != 1 || cap_n != 1 || cap_data[0] !== 16'hBEEF || cap_addr[0] !== 16'h0040) begin
      errors++; $display("FAIL lat1_write got first=%0d n=%0d d=%h a=%h want 1/1/BEEF/0040", cap_first, cap_n, cap_data[0], cap_addr[0]);
    end
    run_req(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000);
    checks++;
    if (cap_first != 1 || cap_n != 1 || cap_data[0] !== 16'hBEEF) begin
      errors++; $display("FAIL lat1_read got first=%0d n=%0d d=%h want 1/1/BEEF", cap_first, cap_n, cap_data[0]);
    end
    run_req(1'b1, 1'b0, 1'b1, 16'h004E, 16'h0000);
    checks++;
    if (cap_first != 1 || cap_n != 8 || cap_addr[0] !== 16'h004E || cap_addr[1] !== 16'h0040 || cap_data[1] !== 16'hBEEF) begin
      errors++; $display("FAIL lat1_burst got first=%0d n=%0d a0=%h a1=%h d1=%h want 1/8/004E/0040/BEEF", cap_first, cap_n, cap_addr[0], cap_addr[1], cap_data[1]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a_valid = 1'b0; a_wr = 1'b0; a_burst = 1'b0; a_addr = 16'h0000; a_wdata = 16'h0000;
    b_valid = 1'b0; b_wr = 1'b0; b_burst = 1'b0; b_addr = 16'h0000; b_wdata = 16'h0000;
    test_reset();
    test_write_read();
    test_burst();
    test_backpressure();
    test_reset_mid_burst();
    test_alias();
    test_burst_write();
    test_latency1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
